// File: rtl/simd_alu_pipe.sv
// rtl/simd_alu_pipe.sv - pipelined SIMD execute unit with lane masking, saturation, reduction and backpressure
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand bundle handshake (op, sat, lane_mask, src_a, src_b)
//   out_valid / out_ready    result bundle handshake (result, flags)
//   result                   LANES x WIDTH lane results, lane i = [i*WIDTH +: WIDTH]
//   flags                    LANES x {N,Z,C,V}, lane i = [i*4 +: 4]
//   err                      sticky, set when an illegal op is accepted
module simd_alu_pipe #(
    parameter int LANES  = 16,
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic                     sat,
    input  logic [LANES-1:0]         lane_mask,
    input  logic [LANES*WIDTH-1:0]   src_a,
    input  logic [LANES*WIDTH-1:0]   src_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   result,
    output logic [LANES*4-1:0]       flags,
    output logic                     err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int RW  = LANES * WIDTH;
    localparam int FW  = LANES * 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MIN  = 4'd7;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] OP_MOVB = 4'd9;
    localparam logic [3:0] OP_RSUM = 4'd10;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             stall;
    logic             accept;
    logic             illegal_op;
    logic [RW-1:0]    comp_result;
    logic [FW-1:0]    comp_flags;

    logic [STAGES-1:0] stg_valid;
    logic [RW-1:0]     stg_result [STAGES];
    logic [FW-1:0]     stg_flags  [STAGES];
    logic              err_q;

    assign stall      = stg_valid[STAGES-1] & ~out_ready;
    assign in_ready   = ~stall;
    assign accept     = in_valid & in_ready;
    assign illegal_op = (op > OP_RSUM);

    always_comb begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] rsum;
        logic             c;
        logic             v;

        comp_result = '0;
        comp_flags  = '0;
        a    = '0;
        b    = '0;
        r    = '0;
        ext  = '0;
        c    = 1'b0;
        v    = 1'b0;
        rsum = '0;

        for (int i = 0; i < LANES; i++) begin
            if (lane_mask[i]) begin
                rsum = rsum + src_a[i*WIDTH +: WIDTH];
            end
        end

        for (int i = 0; i < LANES; i++) begin
            a   = src_a[i*WIDTH +: WIDTH];
            b   = src_b[i*WIDTH +: WIDTH];
            r   = '0;
            ext = '0;
            c   = 1'b0;
            v   = 1'b0;
            case (op)
                OP_ADD: begin
                    ext = {1'b0, a} + {1'b0, b};
                    r   = ext[WIDTH-1:0];
                    c   = ext[WIDTH];
                    v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    ext = {1'b0, a} - {1'b0, b};
                    r   = ext[WIDTH-1:0];
                    c   = ~ext[WIDTH];
                    v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                end
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                OP_SHL:  r = a << b[SHW-1:0];
                OP_SHR:  r = a >> b[SHW-1:0];
                OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
                OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
                OP_MOVB: r = b;
                default: r = '0;
            endcase

            // On overflow the true result has the sign of a, so clamp toward it.
            if (sat && v && (op == OP_ADD || op == OP_SUB)) begin
                r = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
            end

            if (op == OP_RSUM) begin
                // The reduction lands in lane 0 regardless of its mask bit.
                if (i == 0) begin
                    comp_result[WIDTH-1:0] = rsum;
                    comp_flags[3:0]        = {rsum[WIDTH-1], (rsum == '0), 2'b00};
                end
            end else if (illegal_op) begin
                comp_result[i*WIDTH +: WIDTH] = '0;
            end else if (!lane_mask[i]) begin
                comp_result[i*WIDTH +: WIDTH] = a;
            end else begin
                comp_result[i*WIDTH +: WIDTH] = r;
                comp_flags[i*4 +: 4]          = {r[WIDTH-1], (r == '0), c, v};
            end
        end
    end

    // Stage 0 captures the computed bundle; later stages are plain delay.
    // A stall freezes every stage so nothing is lost or duplicated.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            err_q     <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                stg_result[s] <= '0;
                stg_flags[s]  <= '0;
            end
        end else if (!stall) begin
            stg_valid[0]  <= in_valid;
            stg_result[0] <= comp_result;
            stg_flags[0]  <= comp_flags;
            for (int s = 1; s < STAGES; s++) begin
                stg_valid[s]  <= stg_valid[s-1];
                stg_result[s] <= stg_result[s-1];
                stg_flags[s]  <= stg_flags[s-1];
            end
            if (accept && illegal_op) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_valid = stg_valid[STAGES-1];
    assign result    = stg_result[STAGES-1];
    assign flags     = stg_flags[STAGES-1];
    assign err       = err_q;

endmodule
